serial_sub_ctrl: RTL and testbench

//  Bit-serial controller that sequences one external 1-bit full-subtractor cell
//  (Diff = A^B^Bin, Borr = ~A&B | ~(A^B)&Bin) to compute A - B - bin_in over WIDTH bits.

---
 rtl/serial_sub_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_ctrl
// Purpose  : Bit-serial controller that drives an external 1-bit full-
//            subtractor cell LSB-first to compute a_in - b_in - bin_in over
//            WIDTH bits, with a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             cell_a,
    output logic             cell_b,
    output logic             cell_bin,
    input  logic             cell_diff,
    input  logic             cell_borr
);

    localparam int               CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic             r_brw;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    // The final bit is processed on the edge where the counter reads WIDTH-1.
    assign w_last = (r_cnt == c_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and handshake/cell outputs; the cell only sees live
    // operand bits while running, otherwise its inputs are held at zero.
    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        cell_a   = 1'b0;
        cell_b   = 1'b0;
        cell_bin = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                cell_a   = r_a_sr[0];
                cell_b   = r_b_sr[0];
                cell_bin = r_brw;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand latching, serial shifting, borrow chaining and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_d_sr     <= '0;
            r_brw      <= 1'b0;
            r_cnt      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr <= a_in;
                        r_b_sr <= b_in;
                        r_brw  <= bin_in;
                        r_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_d_sr <= {cell_diff, r_d_sr[WIDTH-1:1]};
                    r_brw  <= cell_borr;
                    r_cnt  <= r_cnt + c_ONE;
                    if (w_last) begin
                        // Publish the fully assembled result including this bit.
                        diff       <= {cell_diff, r_d_sr[WIDTH-1:1]};
                        borrow_out <= cell_borr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub_ctrl
// Purpose  : Self-checking bench for serial_sub_ctrl with a behavioural
//            subtractor cell and an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             cell_a;
    logic             cell_b;
    logic             cell_bin;
    logic             cell_diff;
    logic             cell_borr;

    int total;
    int bad;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .cell_a     (cell_a),
        .cell_b     (cell_b),
        .cell_bin   (cell_bin),
        .cell_diff  (cell_diff),
        .cell_borr  (cell_borr)
    );

    // Behavioural 1-bit full subtractor cell.
    assign cell_diff = cell_a ^ cell_b ^ cell_bin;
    assign cell_borr = (~cell_a & cell_b) | (~(cell_a ^ cell_b) & cell_bin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation starting from a negedge with the DUT idle. After the
    // accept edge the inputs are replaced by ga/gb/gbin; start is either
    // dropped or kept high (hold) so requests arrive while busy.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input bit hold, input logic [7:0] ga, input logic [7:0] gb,
                         input logic gbin);
        int n;
        int busy_cnt;
        int exp_i;
        logic [7:0] exp_d;
        logic exp_b;
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        bin_in = bin;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        a_in   = ga;
        b_in   = gb;
        bin_in = gbin;
        check("run_cell_a", 32'(cell_a), 32'(a[0]));
        check("run_cell_b", 32'(cell_b), 32'(b[0]));
        check("run_cell_bin", 32'(cell_bin), 32'(bin));
        busy_cnt = busy ? 1 : 0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
        end
        check("done_latency", 32'(n), 32'(WIDTH));
        exp_i = int'(a) - int'(b) - int'(bin);
        exp_d = 8'(exp_i + 256);
        exp_b = (int'(a) < int'(b) + int'(bin));
        check("diff", 32'(diff), 32'(exp_d));
        check("borrow_out", 32'(borrow_out), 32'(exp_b));
        @(posedge clk);
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("busy_cycles", 32'(busy_cnt), 32'(WIDTH + 1));
        check("idle_cell_a", 32'(cell_a | cell_b | cell_bin), 32'd0);
        check("diff_hold", 32'(diff), 32'(exp_d));
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        bin_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        check("rst_cells", 32'(cell_a | cell_b | cell_bin), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic, wrap-around and boundary operands.
        do_op(8'd100, 8'd37, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        do_op(8'd5,   8'd9,  1'b0, 1'b0, 8'hAA, 8'h55, 1'b1);
        do_op(8'd0,   8'd0,  1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        do_op(8'hFF,  8'd0,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Requests while busy are ignored; the idle one is then accepted.
        do_op(8'd50, 8'd20, 1'b0, 1'b1, 8'd1, 8'd2, 1'b0);
        do_op(8'd1,  8'd2,  1'b0, 1'b0, 8'd0, 8'd0, 1'b0);

        // Reset in the fourth RUN cycle aborts immediately.
        start  = 1'b1;
        a_in   = 8'd7;
        b_in   = 8'd3;
        bin_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        check("abort_cells", 32'(cell_a | cell_b | cell_bin), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'd200, 8'd100, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);

        // Back-to-back random operations with start held high throughout.
        for (int i = 0; i < 1000; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b1,
                  8'($urandom), 8'($urandom), 1'($urandom));
        end
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
